// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the RV32 multi-cycle control path.
// Holds opcode values, ALUOp and ALU operation encodings, datapath mux
// selects, the sequencer state encoding and the control-strobe bundle.
package rv_ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT_W  = 4;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned OPER_W   = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned STATE_W  = 4;

    // Supported major opcodes (IR[6:0])
    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    // ALUOp encodings driven into ALU_Control
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    // ALU operation codes produced by ALU_Control
    localparam logic [OPER_W-1:0] OPER_AND = 4'b0000;
    localparam logic [OPER_W-1:0] OPER_OR  = 4'b0001;
    localparam logic [OPER_W-1:0] OPER_ADD = 4'b0010;
    localparam logic [OPER_W-1:0] OPER_SUB = 4'b0110;
    localparam logic [OPER_W-1:0] OPER_SLT = 4'b0111;

    // ALU operand selects
    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_REGA  = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_REGB  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEMADR   = 4'd5,
        S_MEMREAD  = 4'd6,
        S_MEMWRITE = 4'd7,
        S_MEM_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
    } state_e;

    // Per-cycle datapath strobes issued by the sequencer
    typedef struct packed {
        logic               mem_req;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               pc_write;
        logic               pc_src;
        logic [SEL_W-1:0]   alu_src_a;
        logic [SEL_W-1:0]   alu_src_b;
        logic               mem_to_reg;
        logic               reg_write;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/ALU_Control.sv
// ALU operation decoder.
// Ports: alu_op_i (add/sub/use funct), funct_i ({IR[30], IR[14:12]}),
//        operation_o (4-bit ALU operation).
module ALU_Control
    import rv_ctrl_pkg::*;
(
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [OPER_W-1:0]  operation_o
);

    // Fixed add/sub for address and compare, funct decode for ALU instructions
    always_comb begin
        operation_o = OPER_ADD;
        case (alu_op_i)
            ALUOP_ADD: operation_o = OPER_ADD;
            ALUOP_SUB: operation_o = OPER_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    4'b0000: operation_o = OPER_ADD;
                    4'b1000: operation_o = OPER_SUB;
                    4'b0111: operation_o = OPER_AND;
                    4'b0110: operation_o = OPER_OR;
                    4'b0010: operation_o = OPER_SLT;
                    default: operation_o = OPER_ADD;
                endcase
            end
            default: operation_o = OPER_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32 subset (R-type, I-ALU, lw, sw, beq).
// One FSM issues per-state datapath strobes; instruction and data accesses
// share one req/ready memory port guarded by a wait-state timeout.
// Ports: clk, reset (async, active-low); Opcode/Funct/Zero from datapath;
//        mem_ready/mem_req memory handshake; IorD, MemRead, MemWrite, IRWrite,
//        PCWrite, PCSrc, ALUSrcA, ALUSrcB, MemtoReg, RegWrite, Operation
//        datapath controls; illegal_op, bus_err sticky status; retired count.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic [FUNCT_W-1:0]  Funct,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCSrc,
    output logic [SEL_W-1:0]    ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic [OPER_W-1:0]   Operation,
    output logic                illegal_op,
    output logic                bus_err,
    output logic [CNT_W-1:0]    retired
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                illegal_q, illegal_d;
    logic                bus_err_q, bus_err_d;

    ctrl_t               ctrl_c;
    ctrl_t               ctrl_gated_c;
    logic [FUNCT_W-1:0]  alu_funct_c;
    logic [OPER_W-1:0]   operation_c;
    logic                retire_c;
    logic                timeout_c;

    // State and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state and Moore strobes; a ready in the timeout cycle still completes
    always_comb begin
        state_d     = state_q;
        ctrl_c      = '0;
        alu_funct_c = Funct;
        retire_c    = 1'b0;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        timeout_c   = (wait_q == WAIT_W'(MEM_TIMEOUT));

        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_a = SRCA_PC;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_op    = ALUOP_ADD;
                if (mem_ready) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    state_d         = S_DECODE;
                end else if (timeout_c) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_DECODE: begin
                ctrl_c.alu_src_a = SRCA_OLDPC;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
                case (Opcode)
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_EXEC_R: begin
                ctrl_c.alu_src_a = SRCA_REGA;
                ctrl_c.alu_src_b = SRCB_REGB;
                ctrl_c.alu_op    = ALUOP_FUNCT;
                state_d          = S_ALU_WB;
            end
            S_EXEC_I: begin
                // IR[30] is immediate data for I-type, not a sub selector
                ctrl_c.alu_src_a = SRCA_REGA;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_FUNCT;
                alu_funct_c      = {1'b0, Funct[2:0]};
                state_d          = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl_c.reg_write = 1'b1;
                retire_c         = 1'b1;
                state_d          = S_FETCH;
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a = SRCA_REGA;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
                state_d          = (Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctrl_c.mem_req  = 1'b1;
                ctrl_c.mem_read = 1'b1;
                ctrl_c.iord     = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout_c) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEMWRITE: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.mem_write = 1'b1;
                ctrl_c.iord      = 1'b1;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else if (timeout_c) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEM_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                retire_c          = 1'b1;
                state_d           = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a = SRCA_REGA;
                ctrl_c.alu_src_b = SRCB_REGB;
                ctrl_c.alu_op    = ALUOP_SUB;
                ctrl_c.pc_write  = Zero;
                ctrl_c.pc_src    = Zero;
                retire_c         = 1'b1;
                state_d          = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Wait counter runs only while parked in a memory state; any entry restarts it
    always_comb begin
        wait_d = '0;
        if ((state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE)
            && (state_d == state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Retired counter wraps naturally
    always_comb begin
        retired_d = retired_q;
        if (retire_c) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    ALU_Control u_alu_ctl (
        .alu_op_i    (ctrl_c.alu_op),
        .funct_i     (alu_funct_c),
        .operation_o (operation_c)
    );

    // Reset forces every control output low without waiting for a clock
    assign ctrl_gated_c = reset ? ctrl_c : '0;

    assign mem_req    = ctrl_gated_c.mem_req;
    assign IorD       = ctrl_gated_c.iord;
    assign MemRead    = ctrl_gated_c.mem_read;
    assign MemWrite   = ctrl_gated_c.mem_write;
    assign IRWrite    = ctrl_gated_c.ir_write;
    assign PCWrite    = ctrl_gated_c.pc_write;
    assign PCSrc      = ctrl_gated_c.pc_src;
    assign ALUSrcA    = ctrl_gated_c.alu_src_a;
    assign ALUSrcB    = ctrl_gated_c.alu_src_b;
    assign MemtoReg   = ctrl_gated_c.mem_to_reg;
    assign RegWrite   = ctrl_gated_c.reg_write;
    assign Operation  = reset ? operation_c : '0;
    assign illegal_op = illegal_q;
    assign bus_err    = bus_err_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instruction table,
// hand-written halt/timeout/reset sequences, and a randomized instruction
// stream checked cycle by cycle against an instruction-level model.
module tb_multicycle_control;

    localparam int unsigned T_MEM = 4;
    localparam int unsigned CW    = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    Opcode = '0;
    logic [3:0]    Funct = '0;
    logic          Zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc;
    logic [1:0]    ALUSrcA, ALUSrcB;
    logic          MemtoReg, RegWrite;
    logic [3:0]    Operation;
    logic          illegal_op, bus_err;
    logic [CW-1:0] retired;

    multicycle_control #(.MEM_TIMEOUT(T_MEM), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .Operation(Operation), .illegal_op(illegal_op), .bus_err(bus_err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc,
                  ALUSrcA, ALUSrcB, MemtoReg, RegWrite, Operation};

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_ret = '0;

    typedef struct {
        logic [6:0] opc;
        logic [3:0] fun;
        logic       zero;
        int         waits;
        int         lat;
        logic [3:0] op;
        int         rw;
        int         pcw;
        int         iord;
    } vec_t;

    typedef struct {
        logic [6:0]  opc;
        logic [3:0]  fun;
        logic        zero;
        logic        rdy;
        logic [16:0] exp;
        bit          retire;
    } cyc_t;

    vec_t tbl[9];
    cyc_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic mreq, input logic iord, input logic mrd,
                                       input logic mwr, input logic irw, input logic pcw,
                                       input logic pcs, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic m2r, input logic rw, input logic [3:0] op);
        return {mreq, iord, mrd, mwr, irw, pcw, pcs, sa, sb, m2r, rw, op};
    endfunction

    // Enters reset mid-cycle, checks outputs drop at once, releases at cycle start
    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("reset_outputs", 32'(obs), 32'd0);
        chk("reset_status", 32'({retired, illegal_op, bus_err}), 32'd0);
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("release_fetch", 32'(obs),
            32'(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, ADD)));
        exp_ret = '0;
    endtask

    // Runs one table instruction, measuring what the DUT does over its lifetime
    task automatic run_vec(input int idx, input vec_t v);
        int cyc, wcnt, rw, pcw, iord_n;
        logic [3:0] opcap;
        bit done;
        cyc = 0; wcnt = 0; rw = 0; pcw = 0; iord_n = 0; opcap = 4'hF; done = 0;
        while (!done && cyc < 24) begin
            Opcode = v.opc; Funct = v.fun; Zero = v.zero;
            if (mem_req && IorD) begin
                mem_ready = (wcnt >= v.waits);
                wcnt++;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            if (ALUSrcA == 2'b01) opcap = Operation;
            if (RegWrite) rw++;
            if (PCWrite) pcw++;
            if (mem_req && IorD) iord_n++;
            cyc++;
            @(posedge clk); #1;
            done = mem_req && !IorD && (ALUSrcB == 2'b01);
        end
        exp_ret = exp_ret + 1'b1;
        chk($sformatf("vec%0d_latency", idx), 32'(cyc), 32'(v.lat));
        chk($sformatf("vec%0d_operation", idx), 32'(opcap), 32'(v.op));
        chk($sformatf("vec%0d_regwrite", idx), 32'(rw), 32'(v.rw));
        chk($sformatf("vec%0d_pcwrite", idx), 32'(pcw), 32'(v.pcw));
        chk($sformatf("vec%0d_dataacc", idx), 32'(iord_n), 32'(v.iord));
        chk($sformatf("vec%0d_retired", idx), 32'(retired), 32'(exp_ret));
    endtask

    task automatic push(input logic [6:0] o, input logic [3:0] f, input logic z,
                        input logic r, input logic [16:0] e, input bit ret);
        cyc_t c;
        c.opc = o; c.fun = f; c.zero = z; c.rdy = r; c.exp = e; c.retire = ret;
        q.push_back(c);
    endtask

    // Instruction-level model: expands one instruction into its expected cycles
    task automatic gen_instr(input int kind, input int wf, input int wm);
        logic [6:0] opc;
        logic [3:0] fun;
        logic       z;
        fun = 4'($urandom);
        z   = 1'($urandom);
        case (kind)
            0:       begin opc = OP_R; fun = {fun[3], 3'b000}; end
            1:       begin opc = OP_I; fun = {fun[3], 3'b000}; end
            2:       opc = OP_LOAD;
            3:       opc = OP_STORE;
            default: opc = OP_BRANCH;
        endcase
        for (int i = 0; i < wf; i++)
            push(7'($urandom), 4'($urandom), 1'($urandom), 1'b0,
                 mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, ADD), 1'b0);
        push(7'($urandom), 4'($urandom), 1'($urandom), 1'b1,
             mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, ADD), 1'b0);
        push(opc, fun, 1'($urandom), 1'($urandom),
             mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, ADD), 1'b0);
        case (kind)
            0, 1: begin
                push(opc, fun, 1'($urandom), 1'($urandom),
                     mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01,
                        (kind == 0) ? 2'b00 : 2'b10, 1'b0, 1'b0,
                        (kind == 0 && fun == 4'b1000) ? SUB : ADD), 1'b0);
                push(opc, fun, 1'($urandom), 1'($urandom),
                     mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, ADD), 1'b1);
            end
            2, 3: begin
                push(opc, fun, 1'($urandom), 1'($urandom),
                     mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, ADD), 1'b0);
                for (int i = 0; i <= wm; i++)
                    push(opc, fun, 1'($urandom), (i == wm),
                         mk(1'b1, 1'b1, (kind == 2), (kind == 3), 1'b0, 1'b0, 1'b0,
                            2'b00, 2'b00, 1'b0, 1'b0, ADD), (kind == 3) && (i == wm));
                if (kind == 2)
                    push(opc, fun, 1'($urandom), 1'($urandom),
                         mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, ADD), 1'b1);
            end
            default: begin
                push(opc, fun, z, 1'($urandom),
                     mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z, z, 2'b01, 2'b00, 1'b0, 1'b0, SUB), 1'b1);
            end
        endcase
    endtask

    task automatic run_queue();
        cyc_t c;
        int n;
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            Opcode = c.opc; Funct = c.fun; Zero = c.zero; mem_ready = c.rdy;
            @(negedge clk);
            chk($sformatf("rand_cycle%0d_outputs", n), 32'(obs), 32'(c.exp));
            chk($sformatf("rand_cycle%0d_retired", n), 32'(retired), 32'(exp_ret));
            @(posedge clk); #1;
            if (c.retire) exp_ret = exp_ret + 1'b1;
            n++;
        end
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 3) == 0) ? int'(T_MEM) : int'($urandom_range(0, 2));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{OP_R,      4'b0000, 1'b0, 0, 4, ADD, 1, 1, 0};
        tbl[1] = '{OP_R,      4'b1000, 1'b0, 0, 4, SUB, 1, 1, 0};
        tbl[2] = '{OP_I,      4'b1000, 1'b0, 0, 4, ADD, 1, 1, 0};
        tbl[3] = '{OP_LOAD,   4'b0010, 1'b0, 3, 8, ADD, 1, 1, 4};
        tbl[4] = '{OP_BRANCH, 4'b0000, 1'b1, 0, 3, SUB, 0, 2, 0};
        tbl[5] = '{OP_BRANCH, 4'b0000, 1'b0, 0, 3, SUB, 0, 1, 0};
        tbl[6] = '{OP_STORE,  4'b0000, 1'b0, 0, 4, ADD, 0, 1, 1};
        tbl[7] = '{OP_LOAD,   4'b0000, 1'b0, int'(T_MEM), 9, ADD, 1, 1, int'(T_MEM) + 1};
        tbl[8] = '{OP_STORE,  4'b0000, 1'b0, int'(T_MEM), 8, ADD, 0, 1, int'(T_MEM) + 1};

        do_reset();

        for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

        // Unsupported opcode: halt, flag, and stay off the bus
        Opcode = 7'b1111111; mem_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("illegal_flag", 32'(illegal_op), 32'd1);
        for (int i = 0; i < 8; i++) begin
            mem_ready = 1'($urandom); Opcode = OP_R; Zero = 1'($urandom);
            @(negedge clk);
            chk($sformatf("halt%0d_strobes", i), 32'(obs[16:4]), 32'd0);
            chk($sformatf("halt%0d_retired", i), 32'(retired), 32'(exp_ret));
        end

        // Store that never gets ready: bus error after the wait budget
        do_reset();
        Opcode = OP_STORE; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        for (int i = 0; i <= int'(T_MEM); i++) begin
            @(negedge clk);
            chk($sformatf("timeout_wait%0d_req", i), 32'({mem_req, MemWrite, IorD}), 32'd7);
            chk($sformatf("timeout_wait%0d_buserr", i), 32'(bus_err), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("timeout_buserr", 32'(bus_err), 32'd1);
        chk("timeout_halt_req", 32'(mem_req), 32'd0);
        chk("timeout_retired", 32'(retired), 32'(exp_ret));

        // Reset in the middle of a load's data access
        do_reset();
        Opcode = OP_LOAD; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("memread_before_reset", 32'({mem_req, MemRead, IorD}), 32'd7);
        do_reset();
        run_vec(100, tbl[0]);

        // Randomized instruction stream against the model
        do_reset();
        for (int i = 0; i < 150; i++) gen_instr(int'($urandom_range(0, 4)), rand_wait(), rand_wait());
        run_queue();
        @(negedge clk);
        chk("rand_status_flags", 32'({illegal_op, bus_err}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
